// File: rtl/pio_pkg.sv
// Shared constants for the edge-capturing input PIO.
//   ADDR_*  : word addresses of the register map
//   EDGE_*  : EDGE_TYPE parameter encodings
//   IRQ_*   : IRQ_MODE parameter encodings
package pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_edge_in_if.sv
// Avalon-MM slave bus of the input PIO, plus the interrupt line.
//   address/chipselect/write_n/writedata : master -> slave
//   readdata (registered, 1-clock latency) and irq : slave -> master
interface pio_edge_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/pio_sync_edge.sv
// Per-bit input synchroniser, one-clock history and edge detector.
//   clk, reset_n : clock, async active-low reset
//   in_port      : asynchronous inputs
//   sync         : in_port after SYNC_STAGES flops
//   edges        : selected edge vector from sync and its previous value
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edges
);

  // chain[0] is the first (metastability-exposed) stage.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]                  prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], in_port};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];

  generate
    if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign edges = ~sync & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edges = sync ^ prev;
    end else begin : g_rise
      assign edges = sync & ~prev;
    end
  endgenerate

endmodule

// File: rtl/pio_edge_in.sv
// Avalon-MM input PIO with synchroniser, edge capture and interrupt.
//   clk, reset_n : clock, async active-low reset
//   bus          : Avalon-MM slave (address/chipselect/write_n/writedata,
//                  registered readdata) and irq
//   in_port      : asynchronous external inputs
// Map: 0 data (sync, RO), 1 reserved, 2 irq_mask (RW), 3 edgecapture (W1C).
module pio_edge_in
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter int IRQ_MODE    = IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_edge_in_if.slave     bus,
  input  logic [WIDTH-1:0] in_port
);

  localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync, edges, edge_armed, clr;
  logic [WIDTH-1:0] irq_mask, edgecapture;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed, wr_en, wr_mask, wr_edge;
  logic [31:0]      rd_next, readdata;

  // Only bits below WIDTH are architecturally meaningful.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .sync   (sync),
    .edges  (edges)
  );

  // Hold off capture until the sync chain and prev have been refilled
  // from real input values, so levels present at reset release are not
  // mistaken for edges against the cleared flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         arm_cnt <= '0;
    else if (!armed)      arm_cnt <= arm_cnt + 1'b1;
  end
  assign armed      = (arm_cnt == ARM_DONE);
  assign edge_armed = armed ? edges : '0;

  assign wr_en   = bus.chipselect && !bus.write_n;
  assign wr_mask = wr_en && (bus.address == ADDR_MASK);
  assign wr_edge = wr_en && (bus.address == ADDR_EDGE);
  assign clr     = wr_edge ? bus.writedata[WIDTH-1:0] : '0;

  // New edges are OR-ed after the clear so a coincident edge survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask    <= '0;
      edgecapture <= '0;
    end else begin
      if (wr_mask) irq_mask <= bus.writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~clr) | edge_armed;
    end
  end

  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA: rd_next[WIDTH-1:0] = sync;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_next[WIDTH-1:0] = edgecapture;
      default:   rd_next = '0;
    endcase
  end

  // Read data is refreshed every clock regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end
  assign bus.readdata = readdata;

  generate
    if (IRQ_MODE == IRQ_LEVEL) begin : g_irq_lvl
      assign bus.irq = |(sync & irq_mask);
    end else begin : g_irq_edge
      assign bus.irq = |(edgecapture & irq_mask);
    end
  endgenerate

endmodule

// File: tb/tb_pio_edge_in.sv
module tb_pio_edge_in;
  import pio_pkg::*;

  localparam int W = 8;
  localparam int ND = 3;

  // Three configurations share one bus and one set of inputs:
  // 0: rising/edge-irq S=2, 1: any/edge-irq S=2, 2: rising/level-irq S=3
  localparam int S_[ND]  = '{2, 2, 3};
  localparam int ET[ND]  = '{EDGE_RISING, EDGE_ANY, EDGE_RISING};
  localparam int IM[ND]  = '{IRQ_EDGE, IRQ_EDGE, IRQ_LEVEL};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   address;
  logic         cs, write_n;
  logic [31:0]  wdata;
  logic [W-1:0] in_port;

  pio_edge_in_if b0 ();
  pio_edge_in_if b1 ();
  pio_edge_in_if b2 ();

  assign b0.address = address; assign b0.chipselect = cs;
  assign b0.write_n = write_n; assign b0.writedata  = wdata;
  assign b1.address = address; assign b1.chipselect = cs;
  assign b1.write_n = write_n; assign b1.writedata  = wdata;
  assign b2.address = address; assign b2.chipselect = cs;
  assign b2.write_n = write_n; assign b2.writedata  = wdata;

  logic [31:0] rd [ND];
  logic        irqv [ND];
  assign rd[0] = b0.readdata; assign irqv[0] = b0.irq;
  assign rd[1] = b1.readdata; assign irqv[1] = b1.irq;
  assign rd[2] = b2.readdata; assign irqv[2] = b2.irq;

  pio_edge_in #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISING), .IRQ_MODE(IRQ_EDGE))
    dut0 (.clk(clk), .reset_n(reset_n), .bus(b0), .in_port(in_port));
  pio_edge_in #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY), .IRQ_MODE(IRQ_EDGE))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(b1), .in_port(in_port));
  pio_edge_in #(.WIDTH(W), .SYNC_STAGES(3), .EDGE_TYPE(EDGE_RISING), .IRQ_MODE(IRQ_LEVEL))
    dut2 (.clk(clk), .reset_n(reset_n), .bus(b2), .in_port(in_port));

  // ---------------- reference model ----------------
  // hist[i] is the input value sampled at clock edge i+1 since reset release.
  // A value sampled at edge j is visible as sync after edge j+S-1.
  logic [W-1:0] hist[$];
  int           n;
  logic [W-1:0] m_ec [ND];
  logic [W-1:0] m_mask;
  logic [31:0]  m_rd [ND];

  function automatic logic [W-1:0] sync_after(int d, int k);
    if (k < S_[d]) return '0;
    return hist[k - S_[d]];
  endfunction

  function automatic logic m_irq(int d);
    if (IM[d] == IRQ_LEVEL) return |(sync_after(d, n) & m_mask);
    return |(m_ec[d] & m_mask);
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    logic [W-1:0] cur, old, ev, clr;
    if (!reset_n) begin
      hist.delete();
      n = 0;
      m_mask = '0;
      for (int d = 0; d < ND; d++) begin m_ec[d] = '0; m_rd[d] = '0; end
    end else begin
      n = n + 1;
      hist.push_back(in_port);
      clr = (cs && !write_n && address == 2'd3) ? wdata[W-1:0] : '0;
      for (int d = 0; d < ND; d++) begin
        case (address)
          2'd0:    m_rd[d] = {24'd0, sync_after(d, n - 1)};
          2'd2:    m_rd[d] = {24'd0, m_mask};
          2'd3:    m_rd[d] = {24'd0, m_ec[d]};
          default: m_rd[d] = '0;
        endcase
        cur = sync_after(d, n - 1);
        old = sync_after(d, n - 2);
        if (ET[d] == EDGE_RISING)       ev = cur & ~old;
        else if (ET[d] == EDGE_FALLING) ev = ~cur & old;
        else                            ev = cur ^ old;
        // capture enabled from edge S+2 on (S+1 clocks of hold-off)
        m_ec[d] = (m_ec[d] & ~clr) | ((n >= S_[d] + 2) ? ev : '0);
      end
      if (cs && !write_n && address == 2'd2) m_mask = wdata[W-1:0];
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_model();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rd%0d@%0d", d, n), rd[d], m_rd[d]);
      chk($sformatf("irq%0d@%0d", d, n), {31'd0, irqv[d]}, {31'd0, m_irq(d)});
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    chk_model();
  endtask

  task automatic steps(int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic bus_wr(logic [1:0] a, logic [31:0] d);
    address = a; cs = 1'b1; write_n = 1'b0; wdata = d;
    step();
    cs = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    address = 2'd0; cs = 1'b0; write_n = 1'b1; wdata = '0; in_port = '1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_rd%0d", d), rd[d], 32'h0);
      chk($sformatf("rst_irq%0d", d), {31'd0, irqv[d]}, 32'h0);
    end

    // inputs held high through reset release: no capture
    reset_n = 1'b1;
    address = 2'd3;
    steps(10);
    chk("arm_ec0", rd[0], 32'h0);
    chk("arm_ec1", rd[1], 32'h0);
    chk("arm_irq0", {31'd0, irqv[0]}, 32'h0);
    address = 2'd0;
    step();
    chk("data_ff", rd[0], 32'h0000_00FF);

    // rising edge on bit0 with mask 0x01
    in_port = '0;
    steps(5);
    bus_wr(2'd3, 32'hFF);
    bus_wr(2'd2, 32'h01);
    address = 2'd3;
    in_port = 8'h01;
    step(); step();
    chk("edge_irq_early", {31'd0, irqv[0]}, 32'h0);
    step();
    chk("edge_irq", {31'd0, irqv[0]}, 32'h1);
    step();
    chk("edge_rd", rd[0], 32'h1);

    // W1C clear
    bus_wr(2'd3, 32'h1);
    chk("w1c_irq", {31'd0, irqv[0]}, 32'h0);
    step();
    chk("w1c_rd", rd[0], 32'h0);

    // clear and new edge in the same clock: edge wins
    in_port = 8'h00;
    steps(4);
    in_port = 8'h01;
    step(); step();
    address = 2'd3; cs = 1'b1; write_n = 1'b0; wdata = 32'h1;
    step();
    cs = 1'b0; write_n = 1'b1;
    chk("edge_wins_irq", {31'd0, irqv[0]}, 32'h1);
    step();
    chk("edge_wins_rd", rd[0], 32'h1);

    // any-edge: bit3 toggled twice with mask 0
    steps(3);
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd3, 32'hFF);
    in_port = 8'h09;
    steps(4);
    in_port = 8'h01;
    steps(4);
    address = 2'd3;
    step();
    chk("any_ec", rd[1], 32'h08);
    chk("any_irq_masked", {31'd0, irqv[1]}, 32'h0);
    bus_wr(2'd2, 32'h08);
    chk("any_irq_mask", {31'd0, irqv[1]}, 32'h1);

    // level mode (S=3) on bit7
    bus_wr(2'd2, 32'h80);
    in_port = 8'h81;
    step(); step();
    chk("lvl_early", {31'd0, irqv[2]}, 32'h0);
    step();
    chk("lvl_on", {31'd0, irqv[2]}, 32'h1);
    in_port = 8'h01;
    step(); step();
    chk("lvl_hold", {31'd0, irqv[2]}, 32'h1);
    step();
    chk("lvl_off", {31'd0, irqv[2]}, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
      cs      = ($urandom_range(0, 3) == 0);
      write_n = 1'($urandom_range(0, 1));
      address = 2'($urandom);
      wdata   = $urandom;
      step();
    end
    cs = 1'b0; write_n = 1'b1;

    // asynchronous reset mid-capture
    in_port = '0;
    steps(5);
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd3, 32'hFF);
    in_port = 8'hA5;
    steps(4);
    address = 2'd3;
    step();
    chk("pre_rst_ec", rd[0], 32'hA5);
    bus_wr(2'd2, 32'hFF);
    chk("pre_rst_irq", {31'd0, irqv[0]}, 32'h1);
    #3;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("mid_rst_rd%0d", d), rd[d], 32'h0);
      chk($sformatf("mid_rst_irq%0d", d), {31'd0, irqv[d]}, 32'h0);
    end
    in_port = '1;
    steps(2);
    reset_n = 1'b1;
    bus_wr(2'd2, 32'hFF);
    address = 2'd3;
    steps(10);
    chk("rearm_ec0", rd[0], 32'h0);
    chk("rearm_ec1", rd[1], 32'h0);
    chk("rearm_irq0", {31'd0, irqv[0]}, 32'h0);
    chk("rearm_irq1", {31'd0, irqv[1]}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_edge_in.md
Name: pio_edge_in

Overview:
- Parametrised Avalon-MM input PIO, WIDTH bits wide. Successor of the single-bit level-interrupt input port.
- Adds a configurable multi-stage input synchroniser, rising/falling/any-edge detection, and a write-1-to-clear edge-capture register.
- Interrupt source is selectable: level or edge.
- Sits on the NIOS data bus beside the FIFO status/handshake inputs; the irq output goes to the CPU interrupt controller.

Parameters:
- WIDTH, 8: number of input bits (1..32).
- SYNC_STAGES, 2: synchroniser flops per bit (2..4).
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge.
- IRQ_MODE, 1: 0 = level (synchronised input & mask), 1 = edge (edgecapture & mask).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH are ignored.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data; zero-extended above WIDTH.
- irq  out  1  interrupt request, active high.

Behaviour:
- Reset: one clock, clk. reset_n is asynchronous and active-low. All flops clear on reset: sync chain, prev, irq_mask, edgecapture, readdata, arm counter.
- Reset values: readdata = 0, irq = 0.
- Synchroniser: in_port passes through SYNC_STAGES flops per bit to give sync.
  - A change stable before clock edge k is visible in sync after edge k+SYNC_STAGES-1.
  - prev is sync delayed by one clock.
- Edge vector, by EDGE_TYPE:
  - rising: sync & ~prev
  - falling: ~sync & prev
  - any: sync ^ prev
- Arm counter: after reset deassertion, edge detection is suppressed for SYNC_STAGES+1 clocks. Inputs held high through reset therefore never produce a spurious capture. The counter saturates; it is not re-armed except by reset.
- Register map (word address):
  - 0 data: read sync. Writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 irq_mask: R/W, WIDTH bits.
  - 3 edgecapture: read; a write clears the bits written as 1 (W1C).
- Write strobe: chipselect && !write_n && address match.
- Read path: readdata is updated every clock from the address mux, regardless of chipselect. Read latency is 1 clock.
- edgecapture update each clock: ec <= (ec & ~clr) | edge_armed.
  - A W1C clear and a new edge on the same bit in the same clock leave the bit SET (edge wins).
  - Captured bits are sticky until cleared or reset.
- irq is combinational from registers only, never directly from in_port:
  - IRQ_MODE 0: irq = |(sync & irq_mask).
  - IRQ_MODE 1: irq = |(edgecapture & irq_mask).
- Edge-mode latency: in_port rising before edge k sets the edgecapture bit and asserts irq after edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 clocks.
- Mask write takes effect the clock after the write. Clearing the mask drops irq without altering edgecapture.
- Reset asserted mid-operation: immediate clear of all state and irq = 0. The arm period restarts on release.
- Pulses shorter than one clk period may be missed; this is not a defect.

Decomposition:
- Package pio_pkg holds:
  - address constants: ADDR_DATA = 0, ADDR_MASK = 2, ADDR_EDGE = 3
  - EDGE_RISING/FALLING/ANY encodings
  - IRQ_LEVEL/IRQ_EDGE encodings
- One sub-module, pio_sync_edge: per-vector synchroniser, prev register and edge logic, parametrised by WIDTH, SYNC_STAGES and EDGE_TYPE. Outputs sync and edge.
- The top level holds the arm counter, registers, read mux and irq.

Test Plan:
- Reset release with in_port = 8'hFF held -> edgecapture reads 0 after 10 clocks; irq = 0; data reads 32'h000000FF.
- EDGE_TYPE 0, mask = 8'h01, in_port bit0 0->1 before edge k -> edgecapture = 8'h01 and irq = 1 after edge k+2. A read of address 3 returns 32'h1 one clock after the address is presented.
- W1C: write 32'h1 to address 3 -> bit0 clears next clock and irq drops. Write 32'h1 in the same clock a new bit0 edge arrives -> bit stays 1 and irq stays 1.
- EDGE_TYPE 2, toggle bit3 twice with mask = 0 -> edgecapture = 8'h08 and irq = 0. Write mask = 8'h08 -> irq = 1 the next clock.
- IRQ_MODE 0, mask = 8'h80, in_port bit7 high -> irq = 1 after SYNC_STAGES clocks. Bit7 low -> irq = 0 after SYNC_STAGES clocks. edgecapture is ignored for irq.
- Assert reset_n low mid-capture with edgecapture = 8'hA5 -> readdata, irq and edgecapture are 0 immediately. Arm suppression is observed again after release.
